// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the KLP32V2 pipeline hazard controller.
package klp32_ctrl_pkg;

  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EM   = 2'b01,
    FWD_MW   = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register fields in, bank controls out.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import klp32_ctrl_pkg::*;

  logic [RA_W-1:0]  i_d_rs1, i_d_rs2, i_e_rs1, i_e_rs2, i_e_rd, i_m_rd, i_w_rd;
  logic             i_d_use_rs1, i_d_use_rs2, i_e_wr_en, i_e_is_load;
  logic             i_m_wr_en, i_w_wr_en, i_redirect, i_dmem_req, i_dmem_ready;
  logic             o_hold_pc, o_hold_fd, o_hold_de, o_hold_em;
  logic             o_bubble_de, o_bubble_mw;
  logic             o_flush_fd, o_flush_de, o_flush_em;
  logic [1:0]       o_fwd_a, o_fwd_b;
  logic             o_d_byp_1, o_d_byp_2;
  logic [1:0]       o_state;
  logic             o_mem_timeout;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt, o_lu_cnt;

  modport master (
    output i_d_rs1, i_d_rs2, i_e_rs1, i_e_rs2, i_e_rd, i_m_rd, i_w_rd,
           i_d_use_rs1, i_d_use_rs2, i_e_wr_en, i_e_is_load,
           i_m_wr_en, i_w_wr_en, i_redirect, i_dmem_req, i_dmem_ready,
    input  o_hold_pc, o_hold_fd, o_hold_de, o_hold_em, o_bubble_de, o_bubble_mw,
           o_flush_fd, o_flush_de, o_flush_em, o_fwd_a, o_fwd_b, o_d_byp_1, o_d_byp_2,
           o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt, o_lu_cnt
  );

  modport slave (
    input  i_d_rs1, i_d_rs2, i_e_rs1, i_e_rs2, i_e_rd, i_m_rd, i_w_rd,
           i_d_use_rs1, i_d_use_rs2, i_e_wr_en, i_e_is_load,
           i_m_wr_en, i_w_wr_en, i_redirect, i_dmem_req, i_dmem_ready,
    output o_hold_pc, o_hold_fd, o_hold_de, o_hold_em, o_bubble_de, o_bubble_mw,
           o_flush_fd, o_flush_de, o_flush_em, o_fwd_a, o_fwd_b, o_d_byp_1, o_d_byp_2,
           o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt, o_lu_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_match.sv
// Register dependency detector: a source depends on a writer only for a real, non-x0 write.
module hazard_match
  import klp32_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] rd,
  input  logic            wr_en,
  input  logic [RA_W-1:0] rs,
  output logic            hit
);

  assign hit = wr_en && (rd == rs) && (rd != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage KLP32V2 pipeline: bank controls,
// forwarding/bypass selects, control-state FSM, dmem watchdog and perf counters.
module pipeline_ctrl
  import klp32_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

  logic m_a, w_a, m_b, w_b, w_d1, w_d2, e_d1, e_d2;
  logic lu, mw, act_mw, act_rd, act_lu;
  fwd_sel_e fwd_a, fwd_b;
  ctrl_state_e state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q, lu_q;

  hazard_match u_m_a  (.rd(bus.i_m_rd), .wr_en(bus.i_m_wr_en), .rs(bus.i_e_rs1), .hit(m_a));
  hazard_match u_w_a  (.rd(bus.i_w_rd), .wr_en(bus.i_w_wr_en), .rs(bus.i_e_rs1), .hit(w_a));
  hazard_match u_m_b  (.rd(bus.i_m_rd), .wr_en(bus.i_m_wr_en), .rs(bus.i_e_rs2), .hit(m_b));
  hazard_match u_w_b  (.rd(bus.i_w_rd), .wr_en(bus.i_w_wr_en), .rs(bus.i_e_rs2), .hit(w_b));
  hazard_match u_w_d1 (.rd(bus.i_w_rd), .wr_en(bus.i_w_wr_en), .rs(bus.i_d_rs1), .hit(w_d1));
  hazard_match u_w_d2 (.rd(bus.i_w_rd), .wr_en(bus.i_w_wr_en), .rs(bus.i_d_rs2), .hit(w_d2));
  hazard_match u_e_d1 (.rd(bus.i_e_rd), .wr_en(bus.i_e_wr_en), .rs(bus.i_d_rs1), .hit(e_d1));
  hazard_match u_e_d2 (.rd(bus.i_e_rd), .wr_en(bus.i_e_wr_en), .rs(bus.i_d_rs2), .hit(e_d2));

  // Only one event acts per cycle: dmem wait beats redirect, redirect beats load-use.
  assign lu     = bus.i_e_is_load && ((bus.i_d_use_rs1 && e_d1) || (bus.i_d_use_rs2 && e_d2));
  assign mw     = bus.i_dmem_req && !bus.i_dmem_ready;
  assign act_mw = mw;
  assign act_rd = bus.i_redirect && !mw;
  assign act_lu = lu && !mw && !bus.i_redirect;

  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (m_a)      fwd_a = FWD_EM;
    else if (w_a) fwd_a = FWD_MW;
    if (m_b)      fwd_b = FWD_EM;
    else if (w_b) fwd_b = FWD_MW;
  end

  // Combinational controls are forced low while reset is held so the banks see idle at once.
  assign bus.o_hold_pc   = !reset && (act_mw || act_lu);
  assign bus.o_hold_fd   = !reset && (act_mw || act_lu);
  assign bus.o_hold_de   = !reset && act_mw;
  assign bus.o_hold_em   = !reset && act_mw;
  assign bus.o_bubble_de = !reset && act_lu;
  assign bus.o_bubble_mw = !reset && act_mw;
  assign bus.o_flush_fd  = !reset && act_rd;
  assign bus.o_flush_de  = !reset && act_rd;
  assign bus.o_flush_em  = !reset && act_rd;
  assign bus.o_fwd_a     = reset ? FWD_NONE : fwd_a;
  assign bus.o_fwd_b     = reset ? FWD_NONE : fwd_b;
  assign bus.o_d_byp_1   = !reset && bus.i_d_use_rs1 && w_d1;
  assign bus.o_d_byp_2   = !reset && bus.i_d_use_rs2 && w_d2;

  always_comb begin
    state_d = RUN;
    if (act_mw)      state_d = MEM_WAIT;
    else if (act_rd) state_d = REDIRECT;
    else if (act_lu) state_d = LU_STALL;
    wd_d = '0;
    if (act_mw) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
  end

  // State, watchdog and saturating counters; the watchdog counts consecutive wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
      lu_q      <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (act_mw && wd_d == WD_MAX) timeout_q <= 1'b1;
      if ((state_q == LU_STALL || state_q == MEM_WAIT) && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (act_rd && flush_q != '1) flush_q <= flush_q + 1'b1;
      if (act_lu && lu_q != '1) lu_q <= lu_q + 1'b1;
    end
  end

  assign bus.o_state       = state_q;
  assign bus.o_mem_timeout = timeout_q;
  assign bus.o_stall_cnt   = stall_q;
  assign bus.o_flush_cnt   = flush_q;
  assign bus.o_lu_cnt      = lu_q;

  lu_after_stall_a : assert property (@(posedge clk) disable iff (reset)
    (state_q == LU_STALL) |-> !lu);

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage KLP32V2 pipeline: Fetch, Decode, Execute, Memory, Writeback.
- Computes per-register-bank hold/bubble/flush controls, Execute-operand forwarding selects and Decode bypass selects.
- Tracks the control state in a small FSM with a data-memory wait watchdog and performance counters.
- Sits at top level beside the FD/DE/EM/MW pipeline registers, which obey its outputs.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 32, performance counter width.
- MEM_TIMEOUT, 255, MEM_WAIT cycles before the timeout flag sets.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- i_d_rs1, i_d_rs2  in  RA_W  source registers of the instruction in Decode (FD register).
- i_d_use_rs1, i_d_use_rs2  in  1  that Decode source is actually read.
- i_e_rs1, i_e_rs2  in  RA_W  source registers of the instruction in Execute (DE register).
- i_e_rd  in  RA_W  Execute destination register.
- i_e_wr_en  in  1  Execute writes its destination.
- i_e_is_load  in  1  Execute holds a load.
- i_m_rd  in  RA_W  Memory-stage destination (EM register).
- i_m_wr_en  in  1  Memory stage writes its destination.
- i_w_rd  in  RA_W  Writeback destination (MW register).
- i_w_wr_en  in  1  Writeback writes its destination.
- i_redirect  in  1  taken branch/jump in EM register (pc_sel).
- i_dmem_req  in  1  Memory stage is accessing dmem.
- i_dmem_ready  in  1  dmem completes this cycle.
- o_hold_pc, o_hold_fd, o_hold_de, o_hold_em  out  1  register keeps its value.
- o_bubble_de, o_bubble_mw  out  1  register loads a NOP (all control bits 0).
- o_flush_fd, o_flush_de, o_flush_em  out  1  register loads a NOP.
- o_fwd_a, o_fwd_b  out  2  Execute operand select: 00 DE data, 01 EM alu_result, 10 MW wb result.
- o_d_byp_1, o_d_byp_2  out  1  Decode takes the Writeback value instead of the regfile read.
- o_state  out  2  FSM state.
- o_mem_timeout  out  1  sticky watchdog flag.
- o_stall_cnt, o_flush_cnt, o_lu_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset: every output is 0, the FSM is in RUN, and all counters are 0. Asynchronous reset mid-stall returns everything to RUN immediately.

Match rule:
- A source matches a writer only if rd equals the source, the writer's wr_en is 1, and rd is not 0.
- x0 never forwards, bypasses or stalls.

Forwarding (combinational, all states):
- o_fwd_a = 01 if i_e_rs1 matches M; else 10 if it matches W; else 00. The youngest writer wins.
- o_fwd_b follows the same rule using i_e_rs2.

Decode bypass:
- o_d_byp_1 = i_d_use_rs1 and i_d_rs1 matches W.
- o_d_byp_2 follows the same rule using rs2.

Event conditions:
- Load-use (lu) = i_e_is_load and a used Decode source matches E.
- Mem-wait (mw) = i_dmem_req and not i_dmem_ready.
- Priority: mw > i_redirect > lu. Only the highest-priority event acts in a cycle.

Event actions (same cycle, combinational):
- mw: hold PC, FD, DE and EM; bubble MW.
- redirect: flush FD, DE and EM. PC loads the target via pc_sel. No hold.
- lu: hold PC and FD; bubble DE. A 1-cycle stall; the dependent instruction then forwards via 10.
- A redirect that coincides with an lu kills the stall: the flush wins and no bubble is inserted.

FSM states:
- RUN=0, LU_STALL=1, MEM_WAIT=2, REDIRECT=3.
- The next state is the state of the acting event; with no event it is RUN.
- MEM_WAIT persists while mw stays 1. On ready, outputs release in that same cycle and the FSM returns to RUN next.
- LU_STALL and REDIRECT last exactly 1 cycle unless a new event fires.
- Assertion: lu must not be 1 in the cycle immediately after LU_STALL.

Watchdog:
- A cycle counter runs in MEM_WAIT and clears on any other state.
- When the counter reaches MEM_TIMEOUT, o_mem_timeout sets and stays set until reset. The holds continue regardless.

Counters (saturate at all-ones):
- o_stall_cnt increments each cycle the FSM is in LU_STALL or MEM_WAIT.
- o_flush_cnt increments on each cycle redirect acts.
- o_lu_cnt increments on each cycle lu acts.

Decomposition:
- Package klp32_ctrl_pkg holds:
  - the ctrl_state_e enum {RUN, LU_STALL, MEM_WAIT, REDIRECT};
  - the fwd_sel_e enum {FWD_NONE=00, FWD_EM=01, FWD_MW=10};
  - RA_W.
- Sub-module hazard_match is combinational: it takes rd, wr_en and rs, and returns hit with the x0 rule built in. It is instantiated per source/writer pair.
- The FSM, watchdog and counters stay in pipeline_ctrl.

Test Plan:
- add x5 in E, i_e_rs1=5 in next add (M: rd=5, wr_en=1) -> o_fwd_a=01. Same with only W rd=5 -> o_fwd_a=10. Both M and W rd=5 -> 01. rd=0 with wr_en=1 -> 00.
- lw x7 in E (i_e_is_load=1, rd=7), Decode rs2=7 used -> 1 cycle: o_hold_pc=o_hold_fd=o_bubble_de=1, state LU_STALL, o_lu_cnt=1. The next cycle returns to RUN with no hold.
- i_dmem_req=1, ready low for 3 cycles -> holds PC/FD/DE/EM and o_bubble_mw=1 for exactly 3 cycles, state MEM_WAIT, o_stall_cnt=3.
- i_redirect=1 together with lu active -> o_flush_fd/de/em=1, o_bubble_de=0, o_flush_cnt=1, o_lu_cnt unchanged.
- MEM_TIMEOUT=4, ready low for 6 cycles -> o_mem_timeout rises after the 4th wait cycle and stays 1 after ready.
- reset asserted mid-MEM_WAIT -> all outputs and counters are 0 and o_state=RUN without waiting for a clock edge.
